// File: rtl/pci_ddr_pkg.sv
// Shared types and helpers for the BAR1 to DDR bridge: FSM states, bus widths
// and the byte-lane mask mapping of a 32-bit access onto a 64-bit DDR word.
package pci_ddr_pkg;

  typedef enum logic [1:0] {IDLE, CMD, RDWAIT, DONE} state_e;

  localparam int DDR_DW = 64;
  localparam int WB_DW  = 32;

  // DDR mask is active-high "do not write"; the unselected half is fully masked.
  function automatic logic [7:0] lane_mask(input logic [3:0] sel, input logic half);
    return half ? {~sel, 4'hF} : {4'hF, ~sel};
  endfunction

endpackage

// File: rtl/pci_ddr_lane.sv
// Combinational lane steering between a 32-bit bus word and a 64-bit DDR word:
// replicated write data, byte mask for the selected half, read half-select.
module pci_ddr_lane
  import pci_ddr_pkg::*;
(
  input  logic              half,
  input  logic [3:0]        sel,
  input  logic [WB_DW-1:0]  wdat,
  input  logic [DDR_DW-1:0] rdata,
  output logic [DDR_DW-1:0] wdata,
  output logic [7:0]        wmask,
  output logic [WB_DW-1:0]  rdat
);

  assign wdata = {wdat, wdat};
  assign wmask = lane_mask(sel, half);
  assign rdat  = half ? rdata[63:32] : rdata[31:0];

endmodule

// File: rtl/pci_ddr_bridge.sv
// Single-beat BAR1 Wishbone target onto the 64-bit DDR user interface: retries
// until DDR init completes, one command outstanding, every DDR wait bounded.
module pci_ddr_bridge
  import pci_ddr_pkg::*;
#(
  parameter int ADDR_W      = 24,
  parameter int TIMEOUT_CYC = 255,
  parameter int DDR_AW      = 21
) (
  input  logic              PCI_CLK,
  input  logic              PCI_RSTn,
  input  logic              wb_cyc,
  input  logic              wb_stb,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_adr,
  input  logic [3:0]        wb_sel,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack,
  output logic              wb_rty,
  output logic              wb_err,
  input  logic              init_done,
  output logic              ddr_cmd_valid,
  input  logic              ddr_cmd_ready,
  output logic              ddr_cmd_we,
  output logic [DDR_AW-1:0] ddr_addr,
  output logic [63:0]       ddr_wdata,
  output logic [7:0]        ddr_wmask,
  input  logic              ddr_rd_valid,
  input  logic [63:0]       ddr_rdata,
  output logic [7:0]        timeout_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  state_e            state_q, state_d;
  logic              ack_q, ack_d, rty_q, rty_d, err_q, err_d;
  logic              cmd_valid_q, cmd_valid_d, we_q, we_d, half_q, half_d;
  logic              drop_q, drop_d;
  logic [DDR_AW-1:0] addr_q, addr_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [7:0]        wmask_q, wmask_d, tcnt_q, tcnt_d;
  logic [31:0]       dat_o_q, dat_o_d;
  logic [TW-1:0]     tmo_q, tmo_d;

  logic              lane_half;
  logic [63:0]       lane_wdata;
  logic [7:0]        lane_wmask;
  logic [31:0]       lane_rdat;
  logic              unused_adr;

  assign unused_adr = ^wb_adr[1:0];

  // Write lanes come from the live address; read lanes from the latched one.
  assign lane_half = (state_q == IDLE) ? wb_adr[2] : half_q;

  pci_ddr_lane u_lane (
    .half  (lane_half),
    .sel   (wb_sel),
    .wdat  (wb_dat_i),
    .rdata (ddr_rdata),
    .wdata (lane_wdata),
    .wmask (lane_wmask),
    .rdat  (lane_rdat)
  );

  always_comb begin
    state_d     = state_q;
    ack_d       = 1'b0;
    rty_d       = 1'b0;
    err_d       = 1'b0;
    cmd_valid_d = cmd_valid_q;
    we_d        = we_q;
    half_d      = half_q;
    drop_d      = drop_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    dat_o_d     = dat_o_q;
    tmo_d       = tmo_q;
    tcnt_d      = tcnt_q;
    unique case (state_q)
      IDLE: begin
        // A master still holding stb in its termination cycle must not re-trigger.
        if (wb_cyc && wb_stb && !(ack_q || rty_q || err_q)) begin
          if (!init_done) begin
            rty_d = 1'b1;
          end else begin
            state_d     = CMD;
            cmd_valid_d = 1'b1;
            we_d        = wb_we;
            half_d      = wb_adr[2];
            addr_d      = wb_adr[DDR_AW+2:3];
            wdata_d     = lane_wdata;
            wmask_d     = lane_wmask;
            tmo_d       = '0;
            drop_d      = 1'b0;
          end
        end
      end
      CMD: begin
        drop_d = drop_q | ~wb_cyc;
        if (ddr_cmd_ready) begin
          cmd_valid_d = 1'b0;
          tmo_d       = '0;
          state_d     = we_q ? DONE : RDWAIT;
        end else if (tmo_q == TMO_LAST) begin
          cmd_valid_d = 1'b0;
          err_d       = 1'b1;
          tcnt_d      = (tcnt_q == 8'hFF) ? tcnt_q : tcnt_q + 8'd1;
          state_d     = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      RDWAIT: begin
        drop_d = drop_q | ~wb_cyc;
        if (ddr_rd_valid) begin
          dat_o_d = lane_rdat;
          ack_d   = ~drop_q & wb_cyc;
          state_d = DONE;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          tcnt_d  = (tcnt_q == 8'hFF) ? tcnt_q : tcnt_q + 8'd1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      DONE: begin
        // Reads acked on entry here; posted writes ack one cycle later.
        if (we_q) ack_d = ~drop_q & wb_cyc;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCI_CLK) begin
    if (!PCI_RSTn) begin
      state_q     <= IDLE;
      ack_q       <= 1'b0;
      rty_q       <= 1'b0;
      err_q       <= 1'b0;
      cmd_valid_q <= 1'b0;
      we_q        <= 1'b0;
      half_q      <= 1'b0;
      drop_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= 8'hFF;
      dat_o_q     <= '0;
      tmo_q       <= '0;
      tcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      rty_q       <= rty_d;
      err_q       <= err_d;
      cmd_valid_q <= cmd_valid_d;
      we_q        <= we_d;
      half_q      <= half_d;
      drop_q      <= drop_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      dat_o_q     <= dat_o_d;
      tmo_q       <= tmo_d;
      tcnt_q      <= tcnt_d;
    end
  end

  assign wb_dat_o      = dat_o_q;
  assign wb_ack        = ack_q;
  assign wb_rty        = rty_q;
  assign wb_err        = err_q;
  assign ddr_cmd_valid = cmd_valid_q;
  assign ddr_cmd_we    = we_q;
  assign ddr_addr      = addr_q;
  assign ddr_wdata     = wdata_q;
  assign ddr_wmask     = wmask_q;
  assign timeout_cnt   = tcnt_q;

endmodule

// File: tb/tb_pci_ddr_bridge.sv
// Scenario bench for pci_ddr_bridge with a queue-based scoreboard and a small DDR responder.
module tb_pci_ddr_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_cyc, wb_stb, wb_we;
  logic [23:0] wb_adr;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat_i, wb_dat_o;
  logic        wb_ack, wb_rty, wb_err, init_done;
  logic        ddr_cmd_valid, ddr_cmd_ready, ddr_cmd_we, ddr_rd_valid;
  logic [20:0] ddr_addr;
  logic [63:0] ddr_wdata, ddr_rdata;
  logic [7:0]  ddr_wmask, timeout_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [20:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } cmd_t;

  cmd_t        exp_cmd_q[$];
  logic [31:0] exp_dat_q[$];

  logic [20:0] cap_addr;
  logic [63:0] cap_wdata;
  logic [7:0]  cap_wmask;
  logic        cap_we;
  logic [31:0] cap_dat;

  always #5 clk = ~clk;

  pci_ddr_bridge dut (
    .PCI_CLK(clk), .PCI_RSTn(rst_n),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_sel(wb_sel), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_ack(wb_ack), .wb_rty(wb_rty), .wb_err(wb_err), .init_done(init_done),
    .ddr_cmd_valid(ddr_cmd_valid), .ddr_cmd_ready(ddr_cmd_ready), .ddr_cmd_we(ddr_cmd_we),
    .ddr_addr(ddr_addr), .ddr_wdata(ddr_wdata), .ddr_wmask(ddr_wmask),
    .ddr_rd_valid(ddr_rd_valid), .ddr_rdata(ddr_rdata), .timeout_cnt(timeout_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bus master plus DDR responder for one access. kind: 0 none, 1 ack, 2 rty, 3 err.
  task automatic do_access(input logic we, input logic [23:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat, input logic [63:0] rdata,
                           input int ready_after, input int rd_lat,
                           output int kind, output int acc_cyc, output int fin_cyc,
                           output int vld_cyc);
    bit accepted;
    kind = 0; acc_cyc = -1; fin_cyc = -1; vld_cyc = 0; accepted = 0;
    wb_cyc = 1; wb_stb = 1; wb_we = we; wb_adr = adr; wb_sel = sel; wb_dat_i = dat;
    for (int c = 0; c < 1000; c++) begin
      tick();
      ddr_cmd_ready = 0;
      ddr_rd_valid  = 0;
      if (wb_ack || wb_rty || wb_err) begin
        kind    = wb_ack ? 1 : (wb_rty ? 2 : 3);
        fin_cyc = c;
        cap_dat = wb_dat_o;
        break;
      end
      if (ddr_cmd_valid && !accepted) begin
        vld_cyc++;
        if (vld_cyc > ready_after) begin
          ddr_cmd_ready = 1; accepted = 1; acc_cyc = c;
          cap_addr = ddr_addr; cap_wdata = ddr_wdata; cap_wmask = ddr_wmask; cap_we = ddr_cmd_we;
        end
      end
      if (accepted && !we && c == acc_cyc + rd_lat) begin
        ddr_rd_valid = 1;
        ddr_rdata    = rdata;
      end
    end
    wb_cyc = 0; wb_stb = 0; ddr_cmd_ready = 0; ddr_rd_valid = 0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 0;
    tick(); tick();
    total++; if ({wb_ack, wb_rty, wb_err, ddr_cmd_valid} !== 4'b0) begin bad++;
      $display("FAIL reset_terms got=%b want=0000", {wb_ack, wb_rty, wb_err, ddr_cmd_valid}); end
    total++; if (wb_dat_o !== 32'h0) begin bad++; $display("FAIL reset_dat got=%h want=0", wb_dat_o); end
    total++; if (ddr_addr !== 21'h0 || ddr_wdata !== 64'h0) begin bad++;
      $display("FAIL reset_cmd addr=%h wdata=%h want=0", ddr_addr, ddr_wdata); end
    total++; if (ddr_wmask !== 8'hFF) begin bad++; $display("FAIL reset_wmask got=%h want=ff", ddr_wmask); end
    total++; if (timeout_cnt !== 8'h0) begin bad++; $display("FAIL reset_tcnt got=%h want=0", timeout_cnt); end
    rst_n = 1;
    tick();
  endtask

  task automatic test_retry();
    int kind, acc, fin, vld;
    init_done = 0;
    for (int i = 0; i < 3; i++) begin
      do_access(0, 24'h02_0000, 4'hF, 32'h0, 64'h0, 0, 1, kind, acc, fin, vld);
      total++; if (kind !== 2 || vld !== 0) begin bad++;
        $display("FAIL retry_%0d kind=%0d cmd_cycles=%0d want kind=2 cmd_cycles=0", i, kind, vld); end
      total++; if (wb_rty !== 1'b0) begin bad++; $display("FAIL retry_width_%0d rty=%b want=0", i, wb_rty); end
    end
    init_done = 1;
    exp_dat_q.push_back(32'h0BAD_F00D);
    do_access(0, 24'h02_0000, 4'hF, 32'h0, 64'hCAFE_0000_0BAD_F00D, 0, 2, kind, acc, fin, vld);
    total++; if (kind !== 1 || cap_dat !== exp_dat_q.pop_front()) begin bad++;
      $display("FAIL retry_then_read kind=%0d dat=%h want kind=1 dat=0badf00d", kind, cap_dat); end
  endtask

  task automatic test_write();
    int kind, acc, fin, vld;
    cmd_t e;
    exp_cmd_q.push_back('{addr: 21'h0, wdata: 64'hDEADBEEF_DEADBEEF, wmask: 8'hCF});
    exp_cmd_q.push_back('{addr: 21'h200, wdata: 64'h12345678_12345678, wmask: 8'hF5});
    exp_cmd_q.push_back('{addr: 21'h3, wdata: 64'hA5A5A5A5_A5A5A5A5, wmask: 8'hFF});
    do_access(1, 24'h00_0004, 4'b0011, 32'hDEADBEEF, 64'h0, 0, 0, kind, acc, fin, vld);
    e = exp_cmd_q.pop_front();
    total++; if (kind !== 1 || fin - acc !== 2) begin bad++;
      $display("FAIL write_ack kind=%0d lat=%0d want kind=1 lat=2", kind, fin - acc); end
    total++; if (cap_addr !== e.addr || cap_wdata !== e.wdata || cap_wmask !== e.wmask || cap_we !== 1'b1) begin bad++;
      $display("FAIL write_cmd got %h/%h/%h we=%b want %h/%h/%h we=1", cap_addr, cap_wdata, cap_wmask, cap_we, e.addr, e.wdata, e.wmask); end
    do_access(1, 24'h00_1000, 4'b1010, 32'h12345678, 64'h0, 2, 0, kind, acc, fin, vld);
    e = exp_cmd_q.pop_front();
    total++; if (kind !== 1 || vld !== 3 || cap_addr !== e.addr || cap_wdata !== e.wdata || cap_wmask !== e.wmask) begin bad++;
      $display("FAIL write_lo kind=%0d vcyc=%0d got %h/%h/%h want 1/3 %h/%h/%h", kind, vld, cap_addr, cap_wdata, cap_wmask, e.addr, e.wdata, e.wmask); end
    do_access(1, 24'h00_001C, 4'b0000, 32'hA5A5A5A5, 64'h0, 0, 0, kind, acc, fin, vld);
    e = exp_cmd_q.pop_front();
    total++; if (kind !== 1 || cap_addr !== e.addr || cap_wmask !== e.wmask) begin bad++;
      $display("FAIL write_sel0 kind=%0d got %h/%h want 1 %h/%h", kind, cap_addr, cap_wmask, e.addr, e.wmask); end
  endtask

  task automatic test_read();
    int kind, acc, fin, vld;
    exp_dat_q.push_back(32'h55667788);
    do_access(0, 24'h00_0008, 4'hF, 32'h0, 64'h11223344_55667788, 0, 3, kind, acc, fin, vld);
    total++; if (kind !== 1 || fin - acc !== 4) begin bad++;
      $display("FAIL read_lo_lat kind=%0d lat=%0d want kind=1 lat=4", kind, fin - acc); end
    total++; if (cap_dat !== exp_dat_q.pop_front() || cap_addr !== 21'h1 || cap_we !== 1'b0) begin bad++;
      $display("FAIL read_lo dat=%h addr=%h we=%b want 55667788/1/0", cap_dat, cap_addr, cap_we); end
    exp_dat_q.push_back(32'h11223344);
    do_access(0, 24'h00_000C, 4'hF, 32'h0, 64'h11223344_55667788, 0, 3, kind, acc, fin, vld);
    total++; if (kind !== 1 || cap_dat !== exp_dat_q.pop_front()) begin bad++;
      $display("FAIL read_hi kind=%0d dat=%h want kind=1 dat=11223344", kind, cap_dat); end
    tick(); tick();
    total++; if (wb_dat_o !== 32'h11223344) begin bad++; $display("FAIL read_hold got=%h want=11223344", wb_dat_o); end
  endtask

  task automatic test_timeout();
    int kind, acc, fin, vld;
    do_access(1, 24'h00_0040, 4'hF, 32'h1, 64'h0, 100000, 0, kind, acc, fin, vld);
    total++; if (kind !== 3 || vld !== 255) begin bad++;
      $display("FAIL cmd_timeout kind=%0d vcyc=%0d want kind=3 vcyc=255", kind, vld); end
    total++; if (timeout_cnt !== 8'd1 || ddr_cmd_valid !== 1'b0) begin bad++;
      $display("FAIL cmd_timeout_cnt cnt=%0d valid=%b want 1/0", timeout_cnt, ddr_cmd_valid); end
    do_access(0, 24'h00_0048, 4'hF, 32'h0, 64'h0, 0, 100000, kind, acc, fin, vld);
    total++; if (kind !== 3 || fin - acc !== 256 || timeout_cnt !== 8'd2) begin bad++;
      $display("FAIL rd_timeout kind=%0d lat=%0d cnt=%0d want 3/256/2", kind, fin - acc, timeout_cnt); end
    exp_cmd_q.push_back('{addr: 21'h9, wdata: 64'h00000077_00000077, wmask: 8'hFE});
    do_access(1, 24'h00_0048, 4'b0001, 32'h77, 64'h0, 0, 0, kind, acc, fin, vld);
    begin
      cmd_t e = exp_cmd_q.pop_front();
      total++; if (kind !== 1 || cap_addr !== e.addr || cap_wmask !== e.wmask || cap_wdata !== e.wdata) begin bad++;
        $display("FAIL after_timeout kind=%0d got %h/%h/%h want 1 %h/%h/%h", kind, cap_addr, cap_wdata, cap_wmask, e.addr, e.wdata, e.wmask); end
    end
  endtask

  task automatic test_reset_mid();
    int kind, acc, fin, vld, acks;
    bit seen;
    seen = 0; acks = 0;
    wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = 24'h00_0010; wb_sel = 4'hF;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (ddr_cmd_valid) begin ddr_cmd_ready = 1; seen = 1; break; end
    end
    tick(); ddr_cmd_ready = 0;
    tick();
    rst_n = 0; wb_cyc = 0; wb_stb = 0;
    tick();
    rst_n = 1;
    total++; if (!seen || wb_dat_o !== 32'h0 || ddr_cmd_valid !== 1'b0 || ddr_addr !== 21'h0) begin bad++;
      $display("FAIL mid_reset_out seen=%b dat=%h valid=%b addr=%h want 1/0/0/0", seen, wb_dat_o, ddr_cmd_valid, ddr_addr); end
    total++; if (ddr_wmask !== 8'hFF || timeout_cnt !== 8'h0) begin bad++;
      $display("FAIL mid_reset_regs wmask=%h cnt=%0d want ff/0", ddr_wmask, timeout_cnt); end
    ddr_rd_valid = 1; ddr_rdata = 64'hFFFF_EEEE_DDDD_CCCC;
    tick();
    ddr_rd_valid = 0;
    for (int c = 0; c < 5; c++) begin
      if (wb_ack || wb_err) acks++;
      tick();
    end
    total++; if (acks !== 0 || wb_dat_o !== 32'h0) begin bad++;
      $display("FAIL stale_rdvalid terms=%0d dat=%h want 0/0", acks, wb_dat_o); end
    exp_dat_q.push_back(32'h9999_0000);
    do_access(0, 24'h00_0014, 4'hF, 32'h0, 64'h9999_0000_1111_2222, 0, 1, kind, acc, fin, vld);
    total++; if (kind !== 1 || cap_dat !== exp_dat_q.pop_front()) begin bad++;
      $display("FAIL read_after_reset kind=%0d dat=%h want kind=1 dat=99990000", kind, cap_dat); end
  endtask

  task automatic test_back_to_back();
    int acks, overlap, rdv_at, cmds;
    bit pending;
    logic [20:0] cur_word;
    logic [23:0] a;
    logic [31:0] e;
    acks = 0; overlap = 0; rdv_at = -1; cmds = 0; pending = 0; cur_word = '0;
    a = 24'h0;
    wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = a; wb_sel = 4'hF;
    exp_dat_q.push_back((a[2] ? 32'hA000_0000 : 32'hB000_0000) | 32'(a >> 3));
    for (int c = 0; c < 200 && acks < 6; c++) begin
      tick();
      ddr_cmd_ready = 0; ddr_rd_valid = 0;
      if (wb_ack) begin
        acks++;
        e = exp_dat_q.pop_front();
        total++; if (wb_dat_o !== e) begin bad++; $display("FAIL b2b_dat_%0d got=%h want=%h", acks, wb_dat_o, e); end
        if (acks < 6) begin
          a = 24'(acks * 4);
          wb_adr = a;
          exp_dat_q.push_back((a[2] ? 32'hA000_0000 : 32'hB000_0000) | 32'(a >> 3));
        end else begin
          wb_cyc = 0; wb_stb = 0;
        end
      end
      if (ddr_cmd_valid) begin
        if (pending) overlap++;
        ddr_cmd_ready = 1; pending = 1; cmds++; cur_word = ddr_addr; rdv_at = c + 1;
      end else if (pending && c == rdv_at) begin
        ddr_rd_valid = 1;
        ddr_rdata = {32'hA000_0000 | 32'(cur_word), 32'hB000_0000 | 32'(cur_word)};
        pending = 0;
      end
    end
    wb_cyc = 0; wb_stb = 0; ddr_cmd_ready = 0; ddr_rd_valid = 0;
    tick();
    total++; if (acks !== 6 || cmds !== 6 || overlap !== 0) begin bad++;
      $display("FAIL b2b_count acks=%0d cmds=%0d overlap=%0d want 6/6/0", acks, cmds, overlap); end
  endtask

  initial begin
    rst_n = 0; wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_adr = '0; wb_sel = '0; wb_dat_i = '0;
    init_done = 0; ddr_cmd_ready = 0; ddr_rd_valid = 0; ddr_rdata = '0;
    test_reset();
    test_retry();
    test_write();
    test_read();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pci_ddr_bridge.md
Name: pci_ddr_bridge

Overview:
- Bridges PCI-target BAR1 accesses (Wishbone-style, 32-bit, single beat) onto the 64-bit DDR controller user command/data interface.
- Sits between the PCI target core and ddr_controller inside the user block.
- Retries accesses until DDR initialisation completes.
- Maps 32-bit words onto 64-bit DDR lanes and bounds every DDR transaction with a timeout.

Parameters:
- ADDR_W, 24, byte-address width of the BAR1 window.
- TIMEOUT_CYC, 255, max cycles waiting for ddr_cmd_ready or ddr_rd_valid before erroring.
- DDR_AW, 21, DDR user address width (64-bit word address).

Ports:
- PCI_CLK  in  1  single clock for the whole block.
- PCI_RSTn  in  1  reset; synchronous, active-low.
- wb_cyc  in  1  cycle valid from PCI target.
- wb_stb  in  1  strobe.
- wb_we  in  1  1=write.
- wb_adr  in  ADDR_W  byte address; [1:0] ignored.
- wb_sel  in  4  byte enables, active-high.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data.
- wb_ack  out  1  normal termination.
- wb_rty  out  1  retry termination (PCI target issues STOP/retry).
- wb_err  out  1  error termination (target-abort).
- init_done  in  1  DDR controller initialisation complete.
- ddr_cmd_valid  out  1  command request.
- ddr_cmd_ready  in  1  controller accepts command.
- ddr_cmd_we  out  1  1=write.
- ddr_addr  out  DDR_AW  64-bit word address = wb_adr[DDR_AW+2:3].
- ddr_wdata  out  64  write data.
- ddr_wmask  out  8  byte mask, 1=masked (not written).
- ddr_rd_valid  in  1  read data strobe, one cycle.
- ddr_rdata  in  64  read data.
- timeout_cnt  out  8  saturating count of timeouts since reset (debug).

Behaviour:
- Reset (PCI_RSTn low at a PCI_CLK edge): state IDLE; wb_ack/wb_rty/wb_err/ddr_cmd_valid=0; wb_dat_o=0; ddr_addr/ddr_wdata=0; ddr_wmask=8'hFF; timeout_cnt=0.
- Reset mid-transaction aborts it with no termination pulse; a later ddr_rd_valid is ignored.
- FSM states: IDLE, CMD, RDWAIT, DONE.
- IDLE, wb_cyc&wb_stb and no termination pulse this cycle:
  - init_done=0: wb_rty=1 for one cycle, stay IDLE.
  - else: latch addr/data/mask, go to CMD.
- Lane mapping:
  - wb_adr[2]=0 selects bytes [31:0]; =1 selects [63:32].
  - ddr_wdata = {wb_dat_i, wb_dat_i}.
  - ddr_wmask = ~wb_sel placed in the selected nibble; other nibble = 4'hF.
  - wb_sel=0 on a write still issues the command with mask 8'hFF.
- CMD:
  - ddr_cmd_valid=1; command fields held stable until ready.
  - On ddr_cmd_valid&ddr_cmd_ready: write → DONE (posted once accepted); read → RDWAIT.
  - A ready in the same cycle valid first rises counts.
- RDWAIT: on ddr_rd_valid, wb_dat_o = selected 32-bit half of ddr_rdata; go to DONE.
- DONE: wb_ack=1 for exactly one cycle, then IDLE. Ack therefore occurs:
  - write: 2 cycles after acceptance;
  - read: 1 cycle after ddr_rd_valid.
- Timeout counter:
  - Cleared on entry to CMD; incremented each cycle in CMD/RDWAIT; reset again on RDWAIT entry.
  - Reaching TIMEOUT_CYC: wb_err=1 for one cycle, ddr_cmd_valid=0, timeout_cnt += 1 (saturates at 255), go to IDLE.
  - A stale ddr_rd_valid arriving in IDLE is dropped.
- wb_cyc dropping in CMD/RDWAIT: transaction still completes on the DDR side; wb_ack is suppressed.
- init_done falling after CMD entry is ignored for that transaction.
- At most one outstanding DDR command; wb_ack/wb_rty/wb_err are mutually exclusive.
- wb_dat_o holds its last value between reads.

Decomposition:
- Shared package pci_ddr_pkg:
  - state enum (IDLE, CMD, RDWAIT, DONE);
  - DDR_DW=64, WB_DW=32;
  - lane-mask function (sel, half) → 8-bit mask.
- One sub-module is natural: pci_ddr_lane, combinational lane steering for write data/mask and read half-select, reused by the future DMA path.
- The FSM and timeout counter remain in the top module.

Test Plan:
- init_done=0, read 0x0002_0000 → wb_rty pulses 1 cycle; no ddr_cmd_valid; repeated attempts retry until init_done=1.
- Write 0xDEADBEEF to adr 0x04, sel=4'b0011 → ddr_addr=0, ddr_wmask=8'hCF, ddr_wdata=64'hDEADBEEF_DEADBEEF; wb_ack 2 cycles after accept.
- Read adr 0x08, ddr_rdata=64'h11223344_55667788 returned 3 cycles after accept → wb_dat_o=0x55667788, wb_ack 1 cycle after rd_valid; adr 0x0C → 0x11223344.
- ddr_cmd_ready held 0 → wb_err at cycle TIMEOUT_CYC, timeout_cnt=1; next access proceeds normally.
- PCI_RSTn low while in RDWAIT, then ddr_rd_valid arrives → no wb_ack; all outputs at reset values; next read correct.
- Back-to-back reads with ready=1 every cycle → exactly one command outstanding; ack count equals request count.
